// File: rtl/ip_amba_apb_slave.sv
// APB completer with a word register file (ID, saturating error count, RW regs) and
// WAIT_STATES PREADY-low cycles per access; all outputs are registered.
module ip_amba_apb_slave #(
  parameter int          PADDR_width = 12,
  parameter int          PDATA_width = 32,
  parameter int          PSTRB_width = 4,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [PADDR_width-1:0] PADDR,
  input  logic [PDATA_width-1:0] PWDATA,
  input  logic [PSTRB_width-1:0] PSTRB,
  input  logic [2:0]             PPROT,
  output logic                   PREADY,
  output logic [PDATA_width-1:0] PRDATA,
  output logic                   PSLVERR
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   write_q, write_d;
  logic [PDATA_width-1:0] wdata_q, wdata_d;
  logic [PSTRB_width-1:0] strb_q, strb_d;
  logic                   err_q, err_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [PDATA_width-1:0] prdata_q, prdata_d;
  logic [PDATA_width-1:0] regs_q [NUM_REGS];
  logic [PDATA_width-1:0] regs_d [NUM_REGS];

  logic [PADDR_width-3:0] word;
  logic                   dec_err;
  logic                   unused_prot;

  assign unused_prot = ^PPROT;

  // Error decode is resolved once at setup so the access phase only replays it.
  always_comb begin
    word    = PADDR[PADDR_width-1:2];
    dec_err = (PADDR[1:0] != 2'b00) || (32'(word) >= NUM_REGS) ||
              (PWRITE && (32'(word) < 2));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? ID_VALUE : '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = PADDR[IW+1:2];
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          err_d   = dec_err;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit happens only on the completing edge and only if the master still holds PSEL.
  always_comb begin
    regs_d = regs_q;
    if ((state_q == S_RESP) && PSEL) begin
      if (err_q) begin
        if (regs_q[1] != '1) regs_d[1] = regs_q[1] + 32'd1;
      end else if (write_q) begin
        for (int b = 0; b < PSTRB_width; b++) begin
          if (strb_q[b]) regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
    regs_d[0] = ID_VALUE;
  end

  always_comb begin
    pready_d  = (state_d == S_RESP);
    pslverr_d = pready_d && err_d;
    prdata_d  = '0;
    if (pready_d && !err_d && !write_d) prdata_d = regs_q[idx_d];
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_ip_amba_apb_slave.sv
// Bench for ip_amba_apb_slave: a 2-wait-state and a zero-wait instance driven by an APB
// master task, checked every cycle against a transfer-level register model.
module tb_ip_amba_apb_slave;

  localparam int          NREGS = 16;
  localparam int          WS_A  = 2;
  localparam int          WS_B  = 0;
  localparam logic [31:0] ID    = 32'hA0B0_0001;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [3:0]  pstrb  [2];
  logic [2:0]  pprot  [2];

  ip_amba_apb_slave #(.NUM_REGS(NREGS), .WAIT_STATES(WS_A), .ID_VALUE(ID)) u_dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  ip_amba_apb_slave #(.NUM_REGS(NREGS), .WAIT_STATES(WS_B), .ID_VALUE(ID)) u_dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, one set per instance.
  logic [1:0]  exp_rdy, exp_err, exp_rchk;
  logic [31:0] exp_rd [2];

  // Hand-computed expectation pinned to the completing cycle of a directed transfer.
  logic        pin_vld;
  int          pin_kind;
  int          pin_d;
  logic [31:0] pin_val;
  string       pin_name;

  // Transfer-level model: register contents and error count per instance.
  logic [31:0] m_reg [2][NREGS];
  logic [31:0] m_cnt [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, d, $time, act, expv);
    end
  endtask

  always @(negedge PCLK) begin
    for (int d = 0; d < 2; d++) begin
      chk("pready", d, 32'(pready[d]), 32'(exp_rdy[d]));
      chk("pslverr", d, 32'(pslverr[d]), 32'(exp_err[d]));
      if (exp_rchk[d]) chk("prdata", d, prdata[d], exp_rd[d]);
    end
    if (pin_vld) begin
      if (pin_kind == 1) chk(pin_name, pin_d, prdata[pin_d], pin_val);
      else               chk(pin_name, pin_d, 32'(pslverr[pin_d]), pin_val);
    end
  end

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0;
      for (int i = 0; i < NREGS; i++) m_reg[d][i] = '0;
    end
  endfunction

  function automatic void model_access(input int d, input bit wr, input logic [11:0] a,
                                       input logic [31:0] wd, input logic [3:0] strb,
                                       output bit e, output logic [31:0] rd);
    int idx;
    idx = int'(a >> 2);
    e   = (a % 4 != 0) || (idx >= NREGS) || (wr && idx < 2);
    rd  = '0;
    if (e) begin
      if (m_cnt[d] != 32'hFFFF_FFFF) m_cnt[d] = m_cnt[d] + 1;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[d][idx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rd = (idx == 0) ? ID : (idx == 1) ? m_cnt[d] : m_reg[d][idx];
    end
  endfunction

  function automatic void set_idle(input int d);
    exp_rdy[d]  = 1'b0;
    exp_err[d]  = 1'b0;
    exp_rchk[d] = 1'b1;
    exp_rd[d]   = '0;
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One APB transfer; abort_k>0 drops PSEL on that access cycle; pchk 1=PRDATA, 2=PSLVERR.
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] strb, input int abort_k, input int pchk,
                      input logic [31:0] pval, input string nm);
    int ws;
    bit e;
    logic [31:0] rd;
    ws = (d == 0) ? WS_A : WS_B;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
    pwdata[d] = wd; pstrb[d] = strb; pprot[d] = 3'($urandom_range(0, 7));
    set_idle(d);
    step();
    for (int k = 1; k <= ws + 1; k++) begin
      if (k == abort_k) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        set_idle(d);
        step();
        return;
      end
      penable[d] = 1'b1;
      if (k == ws + 1) begin
        model_access(d, wr, a, wd, strb, e, rd);
        exp_rdy[d] = 1'b1; exp_err[d] = e; exp_rchk[d] = !wr && !e; exp_rd[d] = rd;
        if (pchk != 0) begin
          pin_vld = 1'b1; pin_kind = pchk; pin_d = d; pin_val = pval; pin_name = nm;
        end
      end else begin
        set_idle(d);
      end
      step();
      pin_vld = 1'b0;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    set_idle(d);
  endtask

  // PENABLE asserted while IDLE without a preceding setup phase.
  task automatic idle_viol(input int d, input bit s);
    psel[d] = s; penable[d] = 1'b1;
    set_idle(d);
    step();
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic reset_mid();
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h008;
    pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF;
    step();
    penable[0] = 1'b1;
    for (int k = 1; k <= WS_A; k++) step();
    // Now in the completing cycle: reset lands before the commit edge.
    #2;
    PRESET = 1'b1;
    model_reset();
    set_idle(0); set_idle(1);
    step();
    psel[0] = 1'b0; penable[0] = 1'b0;
    step();
    PRESET = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected $finish within time limit");
    $fatal(1);
  end

  initial begin
    bit wr;
    int d, idx, ab, gap;
    logic [11:0] a;
    PRESET = 1'b1;
    psel = '0; penable = '0; pwrite = '0;
    for (int i = 0; i < 2; i++) begin
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; pprot[i] = '0;
      set_idle(i);
    end
    pin_vld = 1'b0; pin_kind = 0; pin_d = 0; pin_val = '0; pin_name = "";
    model_reset();
    repeat (3) step();
    PRESET = 1'b0;
    step();

    xfer(0, 0, 12'h000, '0, 4'h0, 0, 1, ID, "id_read_a");
    xfer(1, 0, 12'h000, '0, 4'h0, 0, 1, ID, "id_read_b");
    xfer(0, 0, 12'h004, '0, 4'h0, 0, 1, 32'd0, "errcnt_reset");

    xfer(0, 1, 12'h008, 32'hDEAD_BEEF, 4'hF, 0, 2, 32'd0, "wr8_ok");
    xfer(0, 0, 12'h008, '0, 4'h0, 0, 1, 32'hDEAD_BEEF, "rd8_full");
    xfer(0, 1, 12'h008, 32'h1122_3344, 4'b0101, 0, 0, '0, "");
    xfer(0, 0, 12'h008, '0, 4'h0, 0, 1, 32'hDE22_BE44, "rd8_strb");

    xfer(0, 1, 12'h000, 32'h0BAD_0BAD, 4'hF, 0, 2, 32'd1, "wr_id_err");
    xfer(0, 0, 12'h040, '0, 4'h0, 0, 2, 32'd1, "rd_range_err");
    xfer(0, 0, 12'h006, '0, 4'h0, 0, 2, 32'd1, "rd_unaligned_err");
    xfer(0, 0, 12'h000, '0, 4'h0, 0, 1, ID, "id_unchanged");
    xfer(0, 0, 12'h004, '0, 4'h0, 0, 1, 32'd3, "errcnt_3");

    xfer(0, 1, 12'h00C, 32'h55AA_55AA, 4'hF, 1, 0, '0, "");
    step();
    xfer(0, 0, 12'h00C, '0, 4'h0, 0, 1, 32'd0, "abort_nowrite");
    xfer(0, 0, 12'h004, '0, 4'h0, 0, 1, 32'd3, "abort_nocount");
    xfer(0, 1, 12'h00C, 32'h1234_5678, 4'hF, 0, 0, '0, "");
    xfer(0, 0, 12'h00C, '0, 4'h0, 0, 1, 32'h1234_5678, "after_abort");

    xfer(1, 1, 12'h010, 32'h0BAD_F00D, 4'hF, 0, 2, 32'd0, "zws_wr");
    xfer(1, 0, 12'h010, '0, 4'h0, 0, 1, 32'h0BAD_F00D, "zws_rd");

    idle_viol(0, 1'b0);
    idle_viol(0, 1'b1);
    idle_viol(1, 1'b1);
    xfer(0, 0, 12'h008, '0, 4'h0, 0, 1, 32'hDE22_BE44, "after_viol");

    for (int n = 0; n < 300; n++) begin
      d   = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, NREGS + 1);
      a   = 12'(idx * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = 12'($urandom_range(0, 4095));
      ab  = (d == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, WS_A) : 0;
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), ab, 0, '0, "");
      gap = $urandom_range(0, 3);
      if (gap == 0) step();
      else if (gap == 1) idle_viol(d, 1'($urandom_range(0, 1)));
    end

    reset_mid();
    xfer(0, 0, 12'h008, '0, 4'h0, 0, 1, 32'd0, "rst_no_commit");
    xfer(0, 0, 12'h000, '0, 4'h0, 0, 1, ID, "rst_id");
    xfer(0, 0, 12'h004, '0, 4'h0, 0, 1, 32'd0, "rst_errcnt");
    xfer(1, 0, 12'h010, '0, 4'h0, 0, 1, 32'd0, "rst_reg4_b");

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
